// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the data-memory arbiter slice.
//   DMEM_DEPTH      number of 16-bit words in the data memory
//   ADDR_W_DEF      default address width (log2 of DMEM_DEPTH)
//   DATA_W_DEF      default data word width
//   OWN_*           encoding of who owns the read data returning next cycle
//   starve_next()   saturating increment for the anti-starvation counter
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_DEPTH = 256;
    localparam int ADDR_W_DEF = $clog2(DMEM_DEPTH);
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

    // Counter width covers STARVE_MAX up to 15.
    localparam int STARVE_W = 4;

    function automatic logic [STARVE_W-1:0] starve_next(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] max
    );
        if (cnt >= max) begin
            return max;
        end
        return cnt + 4'd1;
    endfunction

endpackage

// File: rtl/dmem_rd_return.sv
// ---------------------------------------------------------------------------
// dmem_rd_return
// Remembers which port was granted a load and steers the synchronous memory
// read data back to that port one cycle later. The port that did not issue
// the load keeps presenting the last word it received.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   i_cpu_load_gnt      cpu load granted this cycle
//   i_dbg_load_gnt      dbg load granted this cycle
//   i_mem_rdata         memory read data (valid the cycle after the load)
//   o_cpu_rvalid/rdata  cpu read return
//   o_dbg_rvalid/rdata  dbg read return
//   o_rd_owner          current owner of returning data (debug visibility)
// ---------------------------------------------------------------------------
module dmem_rd_return
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_cpu_load_gnt,
    input  logic              i_dbg_load_gnt,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic [1:0]        o_rd_owner
);

    logic [1:0]        r_rd_owner;
    logic [DATA_W-1:0] r_cpu_hold;
    logic [DATA_W-1:0] r_dbg_hold;
    logic              w_cpu_rvalid;
    logic              w_dbg_rvalid;

    // Owner is cleared asynchronously, so a reset during an in-flight load
    // suppresses its rvalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_owner <= OWN_NONE;
            r_cpu_hold <= '0;
            r_dbg_hold <= '0;
        end else begin
            if (i_cpu_load_gnt) begin
                r_rd_owner <= OWN_CPU;
            end else if (i_dbg_load_gnt) begin
                r_rd_owner <= OWN_DBG;
            end else begin
                r_rd_owner <= OWN_NONE;
            end
            if (w_cpu_rvalid) begin
                r_cpu_hold <= i_mem_rdata;
            end
            if (w_dbg_rvalid) begin
                r_dbg_hold <= i_mem_rdata;
            end
        end
    end

    assign w_cpu_rvalid = (r_rd_owner == OWN_CPU);
    assign w_dbg_rvalid = (r_rd_owner == OWN_DBG);

    // The returning port sees the memory output directly; the holds capture
    // it so the value persists after rvalid drops.
    assign o_cpu_rvalid = w_cpu_rvalid;
    assign o_dbg_rvalid = w_dbg_rvalid;
    assign o_cpu_rdata  = w_cpu_rvalid ? i_mem_rdata : r_cpu_hold;
    assign o_dbg_rdata  = w_dbg_rvalid ? i_mem_rdata : r_dbg_hold;
    assign o_rd_owner   = r_rd_owner;

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port data memory between the pipeline MEM stage (cpu)
// and the debug/loader port (dbg). One access is granted per cycle; the cpu
// wins ties unless dbg has lost STARVE_MAX consecutive cycles, in which case
// dbg wins once. Load data returns one cycle after the grant.
// Optional feature macro: DMEM_ARB_LOCK_EN adds input dbg_lock. While it is
// high and the last grant went to dbg, dbg keeps the memory every cycle and
// the cpu is stalled on any request.
// Ports:
//   clock, reset                          clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata                 cpu request
//   cpu_gnt, cpu_stall                    cpu grant, pipeline stall
//   cpu_rvalid, cpu_rdata                 cpu load return
//   dbg_req/we/addr/wdata                 dbg request
//   dbg_gnt, dbg_rvalid, dbg_rdata        dbg grant and load return
//   dbg_lock (DMEM_ARB_LOCK_EN only)      hold dbg priority for bursts
//   mem_en/we/addr/wdata, mem_rdata       memory interface
// Handshake: req is a level held by the requester until gnt is seen in the
// same cycle; the arbiter never latches a request, and a req without gnt is
// simply retried next cycle.
// ---------------------------------------------------------------------------
module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              dbg_lock,
`endif
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_locked;
    logic                w_dbg_win;
    logic                w_cpu_win;
    logic                w_cpu_gnt;
    logic                w_dbg_gnt;
    logic [1:0]          w_rd_owner;

`ifdef DMEM_ARB_LOCK_EN
    logic r_last_dbg;

    // Tracks which side received the most recent grant; idle cycles keep it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_dbg <= 1'b0;
        end else if (w_dbg_gnt) begin
            r_last_dbg <= 1'b1;
        end else if (w_cpu_gnt) begin
            r_last_dbg <= 1'b0;
        end
    end

    assign w_locked = dbg_lock & r_last_dbg;
`else
    assign w_locked = 1'b0;
`endif

    // dbg wins when alone, when it has starved long enough, or when locked.
    assign w_dbg_win = dbg_req & (~cpu_req | w_locked | (r_starve_cnt == STARVE_LIM));
    assign w_cpu_win = cpu_req & ~w_dbg_win & ~w_locked;

    // Reset forces all grants (and hence memory enables) low.
    assign w_cpu_gnt = w_cpu_win & reset;
    assign w_dbg_gnt = w_dbg_win & reset;

    assign cpu_gnt   = w_cpu_gnt;
    assign dbg_gnt   = w_dbg_gnt;
    assign cpu_stall = cpu_req & ~w_cpu_gnt;

    // Counts consecutive cycles in which dbg asked and lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (!dbg_req || w_dbg_gnt || w_locked) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= starve_next(r_starve_cnt, STARVE_LIM);
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    dmem_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .clock          (clock),
        .reset          (reset),
        .i_cpu_load_gnt (w_cpu_gnt & ~cpu_we),
        .i_dbg_load_gnt (w_dbg_gnt & ~dbg_we),
        .i_mem_rdata    (mem_rdata),
        .o_cpu_rvalid   (cpu_rvalid),
        .o_cpu_rdata    (cpu_rdata),
        .o_dbg_rvalid   (dbg_rvalid),
        .o_dbg_rdata    (dbg_rdata),
        .o_rd_owner     (w_rd_owner)
    );

    // Owner is exported by the return block for probing; nothing here
    // consumes it beyond this reduction.
    logic w_owner_unused;
    assign w_owner_unused = ^w_rd_owner;

endmodule
